// File: rtl/player_pos_ctl.sv
// Puck position controller for one player: follows the mouse inside that player's half,
// returns home and holds there for a while after every goal.
module player_pos_ctl #(
  parameter int PLAYER_SIDE    = 0,
  parameter int PLAYERS_RADIUS = 20,
  parameter int MAX_STEP       = 4,
  parameter int MOVE_DIV       = 100000,
  parameter int HOLD_TICKS     = 64
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic [3:0]  player_1_score,
  input  logic [3:0]  player_2_score,
  output logic [11:0] xpos_player,
  output logic [11:0] ypos_player,
  output logic        tracking,
  output logic [1:0]  state_dbg_o
);

  localparam logic [11:0] X_MIN  = 12'((PLAYER_SIDE != 0) ? 513 + PLAYERS_RADIUS : 44 + PLAYERS_RADIUS);
  localparam logic [11:0] X_MAX  = 12'((PLAYER_SIDE != 0) ? 980 - PLAYERS_RADIUS : 511 - PLAYERS_RADIUS);
  localparam logic [11:0] Y_MIN  = 12'(44 + PLAYERS_RADIUS);
  localparam logic [11:0] Y_MAX  = 12'(725 - PLAYERS_RADIUS);
  localparam logic [11:0] HOME_X = 12'((PLAYER_SIDE != 0) ? 874 : 150);
  localparam logic [11:0] HOME_Y = 12'd362;
  localparam logic [11:0] STEP   = 12'(MAX_STEP);

  localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(MOVE_DIV - 1);
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_TRACK  = 2'd0,
    S_RETURN = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [11:0]     x_q, x_d, y_q, y_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      p1_prev_q, p2_prev_q;
  logic            tick, goal;
  logic [11:0]     tgt_x, tgt_y, nxt_x, nxt_y;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lo,
                                        input logic [11:0] hi);
    logic [11:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

  // Move at most STEP toward the target; snap onto it when close enough.
  function automatic logic [11:0] step_to(input logic [11:0] p, input logic [11:0] t);
    logic [11:0] r;
    if (t > p) r = ((t - p) <= STEP) ? t : p + STEP;
    else       r = ((p - t) <= STEP) ? t : p - STEP;
    return r;
  endfunction

  always_comb begin
    tick  = (tick_cnt_q == TICK_LAST);
    goal  = (player_1_score != p1_prev_q) || (player_2_score != p2_prev_q);
    tgt_x = HOME_X;
    tgt_y = HOME_Y;
    if (state_q == S_TRACK) begin
      tgt_x = clamp(xpos_mouse, X_MIN, X_MAX);
      tgt_y = clamp(ypos_mouse, Y_MIN, Y_MAX);
    end
    nxt_x = step_to(x_q, tgt_x);
    nxt_y = step_to(y_q, tgt_y);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    hold_d     = hold_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    case (state_q)
      S_TRACK: begin
        if (tick) begin
          x_d = nxt_x;
          y_d = nxt_y;
        end
        if (goal) state_d = S_RETURN;
      end
      S_RETURN: begin
        if (tick) begin
          x_d = nxt_x;
          y_d = nxt_y;
          if (!goal && nxt_x == HOME_X && nxt_y == HOME_Y) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end
        end
      end
      S_HOLD: begin
        // A fresh goal restarts the hold and beats an expiry landing on the same cycle.
        if (goal) begin
          hold_d = '0;
        end else if (tick) begin
          if (hold_q + 1'b1 == HOLD_LAST) begin
            state_d = S_TRACK;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = S_TRACK;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= S_TRACK;
      x_q        <= HOME_X;
      y_q        <= HOME_Y;
      tick_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
    end
  end

  // Scores are tracked through reset too, so releasing reset never looks like a goal.
  always_ff @(posedge clk_in) begin
    p1_prev_q <= player_1_score;
    p2_prev_q <= player_2_score;
  end

  assign xpos_player = x_q;
  assign ypos_player = y_q;
  assign tracking    = (state_q == S_TRACK);
  assign state_dbg_o = state_q;

endmodule

// File: doc/player_pos_ctl.md
PLAYER_POS_CTL -- requirements
Module: player_pos_ctl

Interface
REQ-001 Parameter PLAYER_SIDE, default 0, 0 = player 1 (left half), 1 = player 2 (right half).
REQ-002 Parameter PLAYERS_RADIUS, default 20, puck radius in pixels.
REQ-003 Parameter MAX_STEP, default 4, max pixels moved per axis per move tick.
REQ-004 Parameter MOVE_DIV, default 100000, clock cycles per move tick.
REQ-005 Parameter HOLD_TICKS, default 64, move ticks held at home after a goal.
REQ-006 clk_in  input  1  system clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 xpos_mouse  input  12  requested x position, unsigned pixels.
REQ-009 ypos_mouse  input  12  requested y position, unsigned pixels.
REQ-010 player_1_score  input  4  current player 1 score from ball controller.
REQ-011 player_2_score  input  4  current player 2 score from ball controller.
REQ-012 xpos_player  output  12  registered puck centre x.
REQ-013 ypos_player  output  12  registered puck centre y.
REQ-014 tracking  output  1  high only in state TRACK.

Function
REQ-015 Allowed box: y in [44+R, 725-R]; x in [44+R, 511-R] for side 0, [513+R, 980-R] for side 1 (R = PLAYERS_RADIUS; defaults 64..705, 64..491, 533..960).
REQ-016 Home: (150, 362) for side 0, (874, 362) for side 1.
REQ-017 Tick counter: counts 0..MOVE_DIV-1 then wraps to 0; move tick is the cycle where counter equals MOVE_DIV-1.
REQ-018 Target in TRACK = mouse position clamped per axis to the allowed box (below min -> min, above max -> max); in RETURN target = home.
REQ-019 On a move tick, per axis independently: |target-pos| <= MAX_STEP -> pos = target; else pos moves MAX_STEP toward target; no change between ticks.
REQ-020 All position arithmetic unsigned 12-bit; clamping guarantees no underflow/overflow; position never leaves the allowed box.
REQ-021 Goal event: any cycle where either score input differs from its value registered the previous cycle (score wrap 15->0 counts).
REQ-022 States: TRACK, RETURN, HOLD.
REQ-023 TRACK: goal event -> RETURN next cycle; else stay.
REQ-024 RETURN: moves toward home per REQ-019; when pos equals home after a tick update -> HOLD with hold count 0.
REQ-025 HOLD: position frozen at home; hold count increments each move tick; when count reaches HOLD_TICKS -> TRACK.
REQ-026 Goal event in RETURN: remain in RETURN; goal event in HOLD: hold count cleared to 0, remain in HOLD.
REQ-027 Goal event has priority over HOLD expiry in the same cycle.
REQ-028 Mouse inputs ignored in RETURN and HOLD.

Reset
REQ-029 While rst high: xpos_player/ypos_player = home, state = TRACK, tracking = 1, tick counter = 0, hold count = 0, previous scores = current score inputs (no goal event on reset release).
REQ-030 Reset asserted mid-RETURN or mid-HOLD aborts it; values per REQ-029 on the next edge.

Verification (bench parameters MOVE_DIV=4, MAX_STEP=4, HOLD_TICKS=3, side 0 unless stated)
REQ-031 Reset, mouse=(150,362) -> position stays (150,362), tracking=1.
REQ-032 Mouse=(160,362) -> x: 154 at tick 1, 158 at tick 2, 160 at tick 3; y unchanged; only on ticks (every 4 cycles).
REQ-033 Mouse=(900,10) side 0 -> target clamped (491,64); side 1 with mouse=(10,900) -> target (533,705); position never outside box.
REQ-034 At (162,362) tracking, player_2_score 0->1 -> tracking=0 next cycle, x 158,154,150 over 3 ticks, HOLD 3 ticks at (150,362) ignoring mouse, then tracking=1.
REQ-035 Second goal during HOLD after 2 ticks -> hold count restarts, 3 further ticks before TRACK; goal and expiry same cycle -> stays HOLD.
REQ-036 rst pulsed during HOLD, scores changed while rst high -> after release tracking=1, position home, no RETURN triggered.
